binary_erode3x3: RTL and testbench
==================================

// Module: binary_erode3x3
// PURPOSE
//   3x3 morphological erosion of the binary pixel stream, placed directly upstream of the
//   connected-component labeller. Removes isolated noise pixels and thin spurs before
//   labelling. Accepts one 1-bit pixel per in_write strobe in raster order. Emits exactly
//   one eroded pixel per input pixel, in the same order, on out_write/out_pixel.
// PARAMETERS
//   MAX_WIDTH  640  line-buffer depth (bits per row); largest frame width supported
// PORTS
//   clock      in   1   system clock
//   reset_n    in   1   synchronous, active-low reset
//   width      in   16  frame width in pixels; sampled on first pixel of each frame
//   height     in   16  frame height in pixels; sampled on first pixel of each frame
//   bypass     in   1   1: out_pixel = centre pixel, with unchanged latency and count
//   in_write   in   1   input pixel strobe; honoured only while in_ready=1
//   in_pixel   in   1   binary input pixel
//   in_ready   out  1   1 in RUN state, 0 in FLUSH/DONE or after geom_err
//   out_write  out  1   output pixel strobe (one-cycle pulse per pixel)
//   out_pixel  out  1   eroded pixel
//   out_done   out  1   one-cycle pulse after the last output pixel of a frame
//   geom_err   out  1   sticky: illegal geometry detected; cleared only by reset
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state=RUN; all counters=0; in_ready=1; out_write=0;
//   out_pixel=0; out_done=0; geom_err=0. Line-buffer contents are don't-care: the row/col
//   counters mask them.
// - Erosion: out(x,y) = AND of the 3x3 neighbourhood centred on (x,y). Out-of-frame
//   neighbours read as 0, so row 0, row H-1, col 0 and col W-1 are always 0 (unless
//   bypass=1). Neighbours never wrap across row ends.
// - Storage: two MAX_WIDTH-bit row buffers plus a 3x3 window register. Index k = y*W+x;
//   N = W*H.
// - FSM RUN:
//   - An accepted input with index j >= W+1 produces output k = j-W-1.
//   - out_write is high on the clock after acceptance, carrying the registered result.
//   - Inputs j <= W produce no output.
//   - Acceptance of input N-1 at edge T moves the FSM to FLUSH at T+1.
// - FSM FLUSH: emits the remaining W+1 outputs (k = N-W-1 .. N-1) on consecutive clocks,
//   T+2 .. T+W+2. Zeros are padded in for the missing bottom/right neighbours.
// - FSM DONE: out_done=1 for the single cycle T+W+3. The FSM returns to RUN at T+W+4 with
//   counters cleared and in_ready=1.
// - Per frame: out_write pulses exactly N times; outputs are always in raster order.
// - in_write may be asserted every cycle or sparsely. The output stream is identical
//   either way; only its timing follows the input.
// - in_write while in_ready=0 is ignored: no state change, pixel dropped. Upstream must
//   wait for in_ready.
// - width/height are latched when the first pixel of a frame (counters=0) is accepted.
//   Later changes take effect at the next frame.
// - Geometry check at frame start: width<3, height<3 or width>MAX_WIDTH ->
//   - geom_err=1 and in_ready=0;
//   - no outputs are produced;
//   - the block stays in this condition until reset.
// - Reset mid-frame: the partial frame is abandoned, with no further out_write and no
//   out_done. The next accepted pixel is index 0 of a new frame.
// - Arithmetic: col/row counters are 16 bit. The pixel index is not stored; end of frame
//   is reached when col=W-1 and row=H-1. Flush count is a 16-bit down-counter loaded
//   with W+1.
// TESTING
// 1. W=5,H=4, all-ones, in_write every other cycle -> 20 out_write pulses; ones only at
//    k=6,7,8,11,12,13; one out_done pulse W+3 clocks after the last input edge.
// 2. W=5,H=5, one 3x3 block of ones centred at (2,2) -> 25 outputs; only k=12 is 1.
//    With an isolated single 1 at (2,2) instead -> all 25 outputs are 0.
// 3. W=160,H=120, random pixels, bypass=1 -> 19200 outputs, bit-identical to the input
//    stream. bypass=0 -> matches a software 3x3 erosion model with zero padding.
// 4. Same frame fed with in_write every cycle vs random gaps -> identical out_pixel
//    sequence. in_write pulsed during FLUSH/DONE -> ignored, output count stays N.
// 5. Reset for one cycle after 7 pixels of a W=5,H=4 frame -> no out_done for that frame.
//    A following full all-ones frame reproduces scenario 1 exactly.
// 6. width=2 (and separately width=MAX_WIDTH+1) at frame start -> geom_err=1, in_ready=0,
//    zero out_write; reset clears both.

Source files
------------

// File: rtl/binary_erode3x3_if.sv
// -----------------------------------------------------------------------------
// binary_erode3x3_if
//   Pixel-stream and status bundle for binary_erode3x3.
//   slave  : the erosion block (consumes pixels and geometry, drives results)
//   master : the upstream/downstream side (drives pixels and geometry)
//   Signals:
//     width, height  frame geometry, sampled on the first pixel of a frame
//     bypass         pass the centre pixel through instead of eroding
//     in_write       input pixel strobe, honoured only while in_ready=1
//     in_pixel       binary input pixel
//     in_ready       block accepts pixels
//     out_write      one-cycle strobe per output pixel
//     out_pixel      eroded (or bypassed) pixel
//     out_done       one-cycle pulse after the last output pixel of a frame
//     geom_err       sticky illegal-geometry flag
// -----------------------------------------------------------------------------
interface binary_erode3x3_if;
    logic [15:0] width;
    logic [15:0] height;
    logic        bypass;
    logic        in_write;
    logic        in_pixel;
    logic        in_ready;
    logic        out_write;
    logic        out_pixel;
    logic        out_done;
    logic        geom_err;

    modport slave (
        input  width, height, bypass, in_write, in_pixel,
        output in_ready, out_write, out_pixel, out_done, geom_err
    );

    modport master (
        output width, height, bypass, in_write, in_pixel,
        input  in_ready, out_write, out_pixel, out_done, geom_err
    );
endinterface

// File: rtl/binary_erode3x3.sv
// -----------------------------------------------------------------------------
// binary_erode3x3
//   3x3 morphological erosion of a raster-order 1-bit pixel stream. Every input
//   pixel yields exactly one output pixel, in the same order; the output lags the
//   input by W+1 pixels, and the last W+1 outputs are flushed after the final
//   input with zeros standing in for the missing bottom row.
//   Ports:
//     clock    system clock
//     reset_n  synchronous active-low reset
//     bus      binary_erode3x3_if.slave (pixel stream, geometry, status)
//   Parameters:
//     MAX_WIDTH  row-buffer depth in pixels (largest supported frame width)
// -----------------------------------------------------------------------------
module binary_erode3x3 #(
    parameter int MAX_WIDTH = 640
) (
    input  logic               clock,
    input  logic               reset_n,
    binary_erode3x3_if.slave   bus
);
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state;
    logic [15:0]     col;        // column of the next pixel to be stepped in
    logic [15:0]     row;        // row of the next pixel to be stepped in
    logic [15:0]     w_q;        // geometry latched at frame start
    logic [15:0]     h_q;
    logic [15:0]     flush_cnt;  // flush steps still to run

    // line0[c] holds row y-1, line1[c] holds row y-2 while row y is arriving.
    logic [MAX_WIDTH-1:0] line0;
    logic [MAX_WIDTH-1:0] line1;

    // Window columns, oldest (left) to newest (right). Bit 2 = top row, bit 0 =
    // bottom (current) row.
    logic [2:0]      win_l;
    logic [2:0]      win_m;
    logic [2:0]      win_r;

    logic            in_ready_q;
    logic            out_write_q;
    logic            out_pixel_q;
    logic            out_done_q;
    logic            geom_err_q;

    // ---------------------------------------------------------------------
    // Step datapath: shared between accepted pixels (RUN) and flush steps.
    // ---------------------------------------------------------------------
    logic            accept;
    logic            first;
    logic            geom_bad;
    logic            flush_step;
    logic            step;
    logic            px;
    logic [AW-1:0]   addr;
    logic [2:0]      new_col;
    logic            all9;
    logic            centre;
    logic [15:0]     cur_w;
    logic [15:0]     cur_h;
    logic            eol;
    logic            eof;
    logic            emit_run;
    logic            erode_run;

    assign accept     = bus.in_write & in_ready_q;
    assign first      = (col == 16'd0) && (row == 16'd0);
    assign geom_bad   = (bus.width < 16'd3) || (bus.height < 16'd3) ||
                        ({16'd0, bus.width} > 32'(MAX_WIDTH));
    assign flush_step = (state == S_FLUSH);
    assign step       = (accept && !(first && geom_bad)) || flush_step;
    assign px         = flush_step ? 1'b0 : bus.in_pixel;
    assign addr       = col[AW-1:0];
    assign new_col    = {line1[addr], line0[addr], px};
    assign all9       = &{win_m, win_r, new_col};

    // After the shift the old right column becomes the centre column; its
    // middle bit is the pixel whose output is being produced. This also holds
    // across a row wrap (col=0), where the centre is the previous row's last
    // pixel.
    assign centre     = win_r[1];

    // Geometry of the frame in progress; on the first pixel use the live value
    // since the latch has not happened yet.
    assign cur_w      = first ? bus.width  : w_q;
    assign cur_h      = first ? bus.height : h_q;
    assign eol        = (col == cur_w - 16'd1);
    assign eof        = eol && (row == cur_h - 16'd1);

    // Input j = row*W+col produces output j-W-1 once j >= W+1.
    assign emit_run   = (row >= 16'd2) || ((row == 16'd1) && (col != 16'd0));

    // Centre sits at (col-1,row-1). col>=2 keeps it off column 0, and col=0
    // maps to the previous row's last column, so it is excluded too. row>=2
    // keeps it off row 0; in RUN the centre never reaches the last row.
    assign erode_run  = all9 && (col >= 16'd2) && (row >= 16'd2);

    // ---------------------------------------------------------------------
    // Line buffers and window: no reset, stale contents are masked by the
    // row/column qualifiers above.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (step) begin
            line0[addr] <= px;
            line1[addr] <= line0[addr];
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_RUN;
            col         <= 16'd0;
            row         <= 16'd0;
            w_q         <= 16'd0;
            h_q         <= 16'd0;
            flush_cnt   <= 16'd0;
            win_l       <= 3'b000;
            win_m       <= 3'b000;
            win_r       <= 3'b000;
            in_ready_q  <= 1'b1;
            out_write_q <= 1'b0;
            out_pixel_q <= 1'b0;
            out_done_q  <= 1'b0;
            geom_err_q  <= 1'b0;
        end else begin
            out_write_q <= 1'b0;
            out_done_q  <= 1'b0;

            if (step) begin
                win_l <= win_m;
                win_m <= win_r;
                win_r <= new_col;
            end

            case (state)
                S_RUN: begin
                    if (accept) begin
                        if (first && geom_bad) begin
                            // Dead until reset: in_ready stays low.
                            geom_err_q <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            if (first) begin
                                w_q <= bus.width;
                                h_q <= bus.height;
                            end
                            out_write_q <= emit_run;
                            out_pixel_q <= bus.bypass ? centre : erode_run;
                            if (eof) begin
                                state      <= S_FLUSH;
                                in_ready_q <= 1'b0;
                                col        <= 16'd0;
                                row        <= 16'd0;
                                flush_cnt  <= cur_w + 16'd1;
                            end else if (eol) begin
                                col <= 16'd0;
                                row <= row + 16'd1;
                            end else begin
                                col <= col + 16'd1;
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    // Remaining outputs are the last column of row H-2 and the
                    // whole of row H-1: all border pixels, so the eroded value
                    // is 0 and only bypass needs the window.
                    out_write_q <= 1'b1;
                    out_pixel_q <= bus.bypass & centre;
                    col         <= (col == w_q - 16'd1) ? 16'd0 : col + 16'd1;
                    flush_cnt   <= flush_cnt - 16'd1;
                    if (flush_cnt == 16'd1) begin
                        state <= S_DONE;
                        col   <= 16'd0;
                    end
                end

                S_DONE: begin
                    // Two cycles: pulse out_done, then reopen the input.
                    if (!out_done_q) begin
                        out_done_q <= 1'b1;
                    end else begin
                        state      <= S_RUN;
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_RUN;
                    in_ready_q <= ~geom_err_q;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_write = out_write_q;
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_done  = out_done_q;
    assign bus.geom_err  = geom_err_q;

endmodule

// File: tb/tb_binary_erode3x3.sv
// -----------------------------------------------------------------------------
// tb_binary_erode3x3
//   Scoreboard bench for binary_erode3x3. The driver pushes the expected pixel
//   for every output it provokes; a monitor process pops and compares on each
//   out_write. Expected images are hand-written for the small frames and come
//   from a direct 3x3 AND over the stored frame for the larger ones.
// -----------------------------------------------------------------------------
module tb_binary_erode3x3;
    localparam int MAXW = 640;
    localparam int MAXN = 19200;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    binary_erode3x3_if bus ();

    binary_erode3x3 #(.MAX_WIDTH(MAXW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int k;
        bit v;
    } exp_t;

    exp_t sb[$];
    int   total    = 0;
    int   bad      = 0;
    int   out_cnt  = 0;
    int   done_cnt = 0;
    bit   img  [0:MAXN-1];
    bit   expv [0:MAXN-1];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Output monitor: one comparison per out_write.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.out_done) done_cnt++;
            if (bus.out_write) begin
                out_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected: got pixel %0b, required no output", bus.out_pixel);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_pixel !== e.v) begin
                        bad++;
                        $display("FAIL pixel k=%0d: got %0b, required %0b", e.k, bus.out_pixel, e.v);
                    end
                end
            end
        end
    endtask

    // Reference erosion: AND of the 3x3 neighbourhood, border forced to 0.
    function automatic void model_erode(input int w, input int h);
        bit v;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                v = 1'b1;
                if (x == 0 || x == w-1 || y == 0 || y == h-1) v = 1'b0;
                else
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++)
                            v = v & img[(y+dy)*w + x + dx];
                expv[y*w + x] = v;
            end
        end
    endfunction

    function automatic void fill(input int n, input bit val);
        for (int i = 0; i < n; i++) begin
            img[i]  = val;
            expv[i] = 1'b0;
        end
    endfunction

    function automatic void copy_bypass(input int n);
        for (int i = 0; i < n; i++) expv[i] = img[i];
    endfunction

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    // mode: 0 every cycle, 1 every other cycle, 2 random gaps.
    // junk: keep in_write high through FLUSH/DONE to prove it is ignored.
    task automatic send_frame(input int w, input int h, input int mode,
                              input bit byp, input bit junk, input string tag);
        int n;
        int t;
        int o0;
        int d0;
        bit found;
        n  = w * h;
        o0 = out_cnt;
        d0 = done_cnt;
        bus.width  = 16'(w);
        bus.height = 16'(h);
        bus.bypass = byp;
        check({tag, "_ready_idle"}, int'(bus.in_ready), 1);
        for (int j = 0; j < n; j++) begin
            if (mode == 1 && j > 0) begin
                bus.in_write = 1'b0;
                @(posedge clock); #1;
            end else if (mode == 2) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.in_write = 1'b0;
                    @(posedge clock); #1;
                end
            end
            bus.in_write = 1'b1;
            bus.in_pixel = img[j];
            if (j >= w + 1) sb.push_back('{k: j-w-1, v: expv[j-w-1]});
            if (j == n - 1)
                for (int k = n - w - 1; k < n; k++) sb.push_back('{k: k, v: expv[k]});
            @(posedge clock); #1;
            if (j == 0) begin
                // Geometry is latched on the first pixel; this must not matter.
                bus.width  = 16'd3;
                bus.height = 16'd3;
            end
        end
        bus.in_write = junk;
        bus.in_pixel = 1'b1;
        t = 0;
        found = 1'b0;
        while (!found && t < w + 12) begin
            @(negedge clock);
            t++;
            if (bus.out_done) found = 1'b1;
            if (t >= w + 2) bus.in_write = 1'b0;
        end
        bus.in_write = 1'b0;
        check({tag, "_done_latency"}, t, w + 3);
        @(negedge clock);
        check({tag, "_ready_after"}, int'(bus.in_ready), 1);
        check({tag, "_done_single"}, int'(bus.out_done), 0);
        #1;
        check({tag, "_out_count"}, out_cnt - o0, n);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        @(posedge clock); #1;
    endtask

    task automatic scen_allones(input string tag);
        fill(20, 1'b1);
        expv[6] = 1; expv[7] = 1; expv[8] = 1;
        expv[11] = 1; expv[12] = 1; expv[13] = 1;
        send_frame(5, 4, 1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        int o0;
        int d0;
        int gw[3];
        int gh[3];

        fork
            monitor();
        join_none

        bus.width    = 16'd5;
        bus.height   = 16'd4;
        bus.bypass   = 1'b0;
        bus.in_write = 1'b0;
        bus.in_pixel = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready",  int'(bus.in_ready),  1);
        check("rst_out_write", int'(bus.out_write), 0);
        check("rst_out_pixel", int'(bus.out_pixel), 0);
        check("rst_out_done",  int'(bus.out_done),  0);
        check("rst_geom_err",  int'(bus.geom_err),  0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // W=5,H=4 all ones, every other cycle
        scen_allones("ones");

        // 3x3 block centred at (2,2): only k=12 survives
        fill(25, 1'b0);
        for (int y = 1; y <= 3; y++)
            for (int x = 1; x <= 3; x++) img[y*5 + x] = 1'b1;
        expv[12] = 1'b1;
        send_frame(5, 5, 0, 1'b0, 1'b0, "block");

        // Same block in bypass: output equals input
        copy_bypass(25);
        send_frame(5, 5, 0, 1'b1, 1'b0, "block_byp");

        // Isolated pixel vanishes; writes during FLUSH/DONE are dropped
        fill(25, 1'b0);
        img[12] = 1'b1;
        send_frame(5, 5, 0, 1'b0, 1'b1, "single");

        // Minimum geometry 3x3 all ones: only the centre survives
        fill(9, 1'b1);
        expv[4] = 1'b1;
        send_frame(3, 3, 0, 1'b0, 1'b0, "min3");

        // Same patterned frame, back-to-back vs random gaps
        for (int i = 0; i < 48; i++) img[i] = ((i % 11) != 3) && ((i % 13) != 7);
        model_erode(8, 6);
        send_frame(8, 6, 0, 1'b0, 1'b0, "pat_dense");
        send_frame(8, 6, 2, 1'b0, 1'b1, "pat_gaps");

        // Large random frame: bypass, then eroded
        for (int i = 0; i < MAXN; i++) img[i] = ($urandom_range(0, 7) != 0);
        copy_bypass(MAXN);
        send_frame(160, 120, 0, 1'b1, 1'b0, "big_byp");
        model_erode(160, 120);
        send_frame(160, 120, 0, 1'b0, 1'b0, "big_erode");

        // Reset after 7 pixels of a W=5,H=4 frame
        o0 = out_cnt;
        d0 = done_cnt;
        bus.width  = 16'd5;
        bus.height = 16'd4;
        bus.bypass = 1'b0;
        for (int j = 0; j < 7; j++) begin
            bus.in_write = 1'b1;
            bus.in_pixel = 1'b1;
            if (j == 6) sb.push_back('{k: 0, v: 1'b0});
            @(posedge clock); #1;
        end
        bus.in_write = 1'b0;
        pulse_reset();
        repeat (15) @(posedge clock);
        #1;
        check("abort_outputs", out_cnt - o0, 1);
        check("abort_done", done_cnt - d0, 0);
        check("abort_sb_empty", sb.size(), 0);
        scen_allones("after_abort");

        // Illegal geometry
        gw[0] = 2;        gh[0] = 4;
        gw[1] = MAXW + 1; gh[1] = 4;
        gw[2] = 5;        gh[2] = 2;
        for (int g = 0; g < 3; g++) begin
            o0 = out_cnt;
            bus.width    = 16'(gw[g]);
            bus.height   = 16'(gh[g]);
            bus.in_write = 1'b1;
            bus.in_pixel = 1'b1;
            repeat (12) @(posedge clock);
            #1;
            bus.in_write = 1'b0;
            repeat (3) @(posedge clock);
            #1;
            check($sformatf("geom%0d_err", g), int'(bus.geom_err), 1);
            check($sformatf("geom%0d_ready", g), int'(bus.in_ready), 0);
            check($sformatf("geom%0d_outputs", g), out_cnt - o0, 0);
            pulse_reset();
            check($sformatf("geom%0d_err_clr", g), int'(bus.geom_err), 0);
            check($sformatf("geom%0d_ready_clr", g), int'(bus.in_ready), 1);
        end

        // Legal frame still works after the error/reset sequence
        scen_allones("post_geom");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
